// File: rtl/debug_trace_fifo_if.sv
// debug_trace_fifo_if: nibble stream from the trace buffer to the board debug pins
interface debug_trace_fifo_if;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_first;
    logic       dout_ready;
    modport master (output dout, dout_valid, dout_first, input dout_ready);
    modport slave  (input dout, dout_valid, dout_first, output dout_ready);
endinterface

// File: rtl/debug_trace_fifo.sv
// debug_trace_fifo: buffers retired-instruction records and streams the selected field as nibbles
module debug_trace_fifo #(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_aresetn,
    input  logic                   clear,
    input  logic                   debug_wb_valid,
    input  logic [31:0]            debug_wb_pc,
    input  logic [31:0]            debug_wb_instr,
    input  logic [31:0]            debug_wb_rf_wdata,
    input  logic [1:0]             mode,
    debug_trace_fifo_if.master     trace,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t      state;
    logic [95:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic [31:0] shreg;
    logic [2:0]  nib;
    logic [95:0] head;
    logic [31:0] field;
    logic        empty, full, active, push_req, pop, push, drop;
    assign head     = mem[rptr[AW-1:0]];
    assign field    = mode == 2'd0 ? head[95:64] : mode == 2'd1 ? head[63:32] : head[31:0];
    assign empty    = wptr == rptr;
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign active   = mode != 2'd3;
    assign push_req = debug_wb_valid && active;
    // a word leaves the FIFO when idle, or back-to-back as the last nibble is accepted
    assign pop      = (state == IDLE || (trace.dout_ready && nib == 3'd0)) && !empty && active;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && !push;
    assign level    = wptr - rptr;
    always_ff @(posedge cpu_clk)
        if (push && !clear) mem[wptr[AW-1:0]] <= {debug_wb_pc, debug_wb_instr, debug_wb_rf_wdata};
    always_ff @(posedge cpu_clk or negedge cpu_aresetn) begin
        if (!cpu_aresetn) begin
            state            <= IDLE;
            wptr             <= '0;
            rptr             <= '0;
            shreg            <= '0;
            nib              <= '0;
            overflow         <= 1'b0;
            drop_cnt         <= '0;
            trace.dout       <= '0;
            trace.dout_valid <= 1'b0;
            trace.dout_first <= 1'b0;
        end else if (clear) begin
            state            <= IDLE;
            wptr             <= '0;
            rptr             <= '0;
            shreg            <= '0;
            nib              <= '0;
            overflow         <= 1'b0;
            drop_cnt         <= '0;
            trace.dout       <= '0;
            trace.dout_valid <= 1'b0;
            trace.dout_first <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
            // shreg holds the not-yet-presented nibbles, MSB first
            if (pop) begin
                state            <= SHIFT;
                shreg            <= {field[27:0], 4'h0};
                nib              <= 3'd7;
                trace.dout       <= field[31:28];
                trace.dout_valid <= 1'b1;
                trace.dout_first <= 1'b1;
            end else if (state == SHIFT && trace.dout_ready) begin
                if (nib == 3'd0) begin
                    state            <= IDLE;
                    trace.dout_valid <= 1'b0;
                    trace.dout_first <= 1'b0;
                end else begin
                    nib              <= nib - 3'd1;
                    shreg            <= shreg << 4;
                    trace.dout       <= shreg[31:28];
                    trace.dout_first <= 1'b0;
                end
            end
        end
    end
endmodule
